ram_boot_loader: RTL and testbench

- Parametrised program/data loader between an external word source and the shared RAMblock bus, ahead of the CUmodule.
- Buffers incoming (address, data) pairs in a small FIFO and writes them into RAM.
- Optionally reads each word back and compares it.
- Releases CU `enable` only after a clean load. This puts into hardware the RAM-preload-then-enable sequence that benches currently do by hand.

---
 rtl/ram_boot_loader_if.sv | 27 ++
 rtl/ram_boot_loader.sv | 189 ++++++++++++++++++
 tb/tb_ram_boot_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_boot_loader_if.sv
// Word-source handshake and RAMblock bus seen by the boot loader.
// slave: the loader side. master: the word source plus the RAM.
interface ram_boot_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_read;
   logic              ram_write;

   modport slave (
      input  in_valid, in_addr, in_data, in_last, ram_rdata,
      output in_ready, ram_addr, ram_wdata, ram_read, ram_write
   );

   modport master (
      output in_valid, in_addr, in_data, in_last, ram_rdata,
      input  in_ready, ram_addr, ram_wdata, ram_read, ram_write
   );
endinterface

// File: rtl/ram_boot_loader.sv
// RAM boot loader: queues (addr, data) words from a source, writes them into
// RAMblock, optionally reads each back to compare, and releases the CU enable
// only after a load session finishes with no verify mismatches.
module ram_boot_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int VERIFY = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   ram_boot_loader_if.slave bus,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_count,
   output logic             fail
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      RDBK,
      FINISH,
      RUN
   } state_t;

   state_t state;

   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [DEPTH-1:0]  fifo_last;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              last_seen;
   logic              cur_last;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              sess_start;

   // FIFO status, source handshake, and the pop decision shared by FIFO and FSM.
   // Pop doubles as "load the FIFO head into the RAM bus and enter WRITE", which
   // lets WRITE/RDBK chain straight into the next word when one is queued.
   always_comb begin
      full         = (count == CNT_W'(DEPTH));
      empty        = (count == '0);
      bus.in_ready = busy & ~full & ~last_seen;
      push         = bus.in_valid & bus.in_ready;
      sess_start   = start & ((state == IDLE) | (state == RUN));
      pop          = 1'b0;
      case (state)
         LOAD:    pop = ~empty;
         WRITE:   pop = (VERIFY == 0) & ~cur_last & ~empty;
         RDBK:    pop = ~cur_last & ~empty;
         default: pop = 1'b0;
      endcase
   end

   // FIFO storage; contents need no reset, only the pointers do.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.in_addr;
         fifo_data[wr_ptr] <= bus.in_data;
         fifo_last[wr_ptr] <= bus.in_last;
      end
   end

   // FIFO pointers, occupancy and the end-of-session marker from the source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_seen <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (sess_start)
            last_seen <= 1'b0;
         else if (push && bus.in_last)
            last_seen <= 1'b1;
      end
   end

   // Session FSM with registered RAM strobes, status and CU enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cpu_enable    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_count     <= '0;
         fail          <= 1'b0;
         cur_last      <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.ram_read  <= 1'b0;
         bus.ram_write <= 1'b0;
      end else begin
         done          <= 1'b0;
         bus.ram_read  <= 1'b0;
         bus.ram_write <= 1'b0;
         if (pop) begin
            bus.ram_addr  <= fifo_addr[rd_ptr];
            bus.ram_wdata <= fifo_data[rd_ptr];
            cur_last      <= fifo_last[rd_ptr];
            bus.ram_write <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  err_count <= '0;
                  fail      <= 1'b0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (pop) begin
                  state <= WRITE;
               end else if (empty && last_seen) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            WRITE: begin
               if (VERIFY != 0) begin
                  bus.ram_read <= 1'b1;
                  state        <= RDBK;
               end else if (cur_last) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (pop) begin
                  state <= WRITE;
               end else begin
                  state <= LOAD;
               end
            end
            RDBK: begin
               if ((bus.ram_rdata != bus.ram_wdata) && (err_count != '1))
                  err_count <= err_count + 1'b1;
               if (cur_last) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else if (pop) begin
                  state <= WRITE;
               end else begin
                  state <= LOAD;
               end
            end
            FINISH: begin
               busy <= 1'b0;
               if (err_count == '0) begin
                  cpu_enable <= 1'b1;
                  state      <= RUN;
               end else begin
                  fail  <= 1'b1;
                  state <= IDLE;
               end
            end
            RUN: begin
               if (start) begin
                  cpu_enable <= 1'b0;
                  busy       <= 1'b1;
                  err_count  <= '0;
                  fail       <= 1'b0;
                  state      <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_boot_loader.sv
// Self-checking bench for ram_boot_loader: a RAM model with forced-bad
// addresses, a word-source driver, and a session-level reference model.
module tb_ram_boot_loader;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int DEPTH   = 4;
   localparam int ERR_W   = 2;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } word_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             cpu_enable;
   logic             busy;
   logic             done;
   logic             fail;
   logic [ERR_W-1:0] err_count;

   ram_boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_boot_loader #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .VERIFY(1),
      .ERR_W (ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bus       (bus),
      .cpu_enable(cpu_enable),
      .busy      (busy),
      .done      (done),
      .err_count (err_count),
      .fail      (fail)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous write, combinational read, some addresses stuck at FFFF.
   logic [DATA_W-1:0] ram [256];
   bit                bad [256];
   always @(posedge clk) if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_wdata;
   assign bus.ram_rdata = bad[bus.ram_addr] ? 16'hFFFF : ram[bus.ram_addr];

   int tests = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor, sampled mid-cycle.
   word_t             wr_q [$];
   word_t             words [$];
   int                cyc = 0;
   int                rd_cnt = 0;
   int                done_cnt = 0;
   int                last_rd_cyc = -1;
   int                en_rise_cyc = -1;
   logic              prev_wr = 1'b0;
   logic [ADDR_W-1:0] prev_wr_addr = '0;
   logic              prev_en = 1'b0;
   bit                saw_bp = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (bus.ram_write) begin
            wr_q.push_back({bus.ram_addr, bus.ram_wdata});
            check("rw_exclusive", bus.ram_read, 1'b0);
         end
         if (bus.ram_read) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            check("rd_after_wr", prev_wr, 1'b1);
            check("rd_addr", bus.ram_addr, prev_wr_addr);
         end
         if (done) done_cnt++;
         if (cpu_enable && !prev_en) en_rise_cyc = cyc;
      end
      prev_wr      = bus.ram_write;
      prev_wr_addr = bus.ram_addr;
      prev_en      = cpu_enable;
   end

   // One load session from the current words queue, judged against the model:
   // every word written once in order, err = saturated count of words whose
   // readback differs, fail/cpu_enable follow from err.
   task automatic run_session(input bit gaps, input bit start_mid, input bit start_fin);
      int    n = words.size();
      int    exp_err = 0;
      int    t;
      bit    acc;
      for (int i = 0; i < n; i++)
         if (bad[words[i].a] && words[i].d != 16'hFFFF && exp_err < ERR_MAX) exp_err++;
      wr_q.delete();
      rd_cnt = 0;
      done_cnt = 0;
      en_rise_cyc = -1;
      last_rd_cyc = -1;
      saw_bp = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("en_off_after_start", cpu_enable, 1'b0);
      check("err_cleared", err_count, 0);
      check("fail_cleared", fail, 1'b0);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_addr  = words[i].a;
         bus.in_data  = words[i].d;
         bus.in_last  = (i == n - 1);
         if (start_mid && i == 1) start = 1'b1;
         t = 0;
         do begin
            acc = bus.in_ready;
            if (!acc && busy) saw_bp = 1'b1;
            @(negedge clk);
            start = 1'b0;
            t++;
         end while (!acc && t < 100);
         if (!acc) begin
            check("push_timeout", 0, 1);
            break;
         end
         if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      t = 0;
      while (!done && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", done, 1'b1);
      if (start_fin) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      check("wr_count", wr_q.size(), n);
      for (int i = 0; i < n && i < wr_q.size(); i++)
         check("wr_word", wr_q[i], words[i]);
      check("rd_count", rd_cnt, n);
      check("done_once", done_cnt, 1);
      check("err_count", err_count, exp_err);
      check("fail", fail, exp_err != 0);
      check("cpu_enable", cpu_enable, exp_err == 0);
      check("busy_end", busy, 1'b0);
      if (exp_err == 0) check("en_latency", en_rise_cyc - last_rd_cyc, 2);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      for (int i = 0; i < 256; i++) bad[i] = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cpu_enable", cpu_enable, 1'b0);
      check("rst_ram_write", bus.ram_write, 1'b0);
      rst_n = 1'b1;

      // in_valid while idle must be ignored
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_no_write", wr_q.size(), 0);
      bus.in_valid = 1'b0;

      // basic load
      words.delete();
      words.push_back('{8'd16, 16'd5});
      words.push_back('{8'd17, 16'd2});
      words.push_back('{8'd1, 16'h0086});
      words.push_back('{8'd2, 16'h018E});
      words.push_back('{8'd3, 16'h0000});
      run_session(0, 0, 0);

      // reload from RUN, with a stray start mid-session and in FINISH
      words.delete();
      for (int i = 0; i < 4; i++) words.push_back('{8'(8'h20 + i), 16'($urandom)});
      run_session(1, 1, 1);

      // backpressure: 8 back-to-back words
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back('{8'(8'h40 + i), 16'($urandom)});
      run_session(0, 0, 0);
      check("backpressure_seen", saw_bp, 1'b1);

      // verify fail at address 17
      bad[17] = 1'b1;
      words.delete();
      words.push_back('{8'd16, 16'h1111});
      words.push_back('{8'd17, 16'h1234});
      words.push_back('{8'd18, 16'h3333});
      run_session(0, 0, 0);
      bad[17] = 1'b0;

      // saturation: 5 mismatches into a 2-bit counter
      words.delete();
      for (int i = 0; i < 5; i++) begin
         bad[8'h80 + i] = 1'b1;
         words.push_back('{8'(8'h80 + i), 16'(16'h0100 + i)});
      end
      run_session(1, 0, 0);
      for (int i = 0; i < 5; i++) bad[8'h80 + i] = 1'b0;

      // async reset in the middle of a write
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 20 && !bus.ram_write; i++) begin
         bus.in_valid = 1'b1;
         bus.in_addr  = 8'(8'h60 + i);
         bus.in_data  = 16'($urandom);
         bus.in_last  = 1'b0;
         @(negedge clk);
      end
      check("abort_write_seen", bus.ram_write, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_in_ready", bus.in_ready, 1'b0);
      check("abort_ram_read", bus.ram_read, 1'b0);
      check("abort_ram_write", bus.ram_write, 1'b0);
      check("abort_cpu_enable", cpu_enable, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_fail", fail, 1'b0);
      check("abort_err", err_count, 0);
      check("abort_ram_addr", bus.ram_addr, 0);
      check("abort_ram_wdata", bus.ram_wdata, 0);
      @(negedge clk) rst_n = 1'b1;
      wr_q.delete();
      repeat (5) begin
         @(negedge clk);
         check("post_abort_in_ready", bus.in_ready, 1'b0);
      end
      check("post_abort_no_write", wr_q.size(), 0);
      bus.in_valid = 1'b0;

      // clean session after abort: FIFO must hold nothing from before
      words.delete();
      words.push_back('{8'h70, 16'hBEEF});
      run_session(0, 0, 0);

      // randomized sessions
      for (int s = 0; s < 10; s++) begin
         n = $urandom_range(1, 10);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back('{8'($urandom), 16'($urandom)});
         if ($urandom_range(0, 2) == 0) bad[words[$urandom_range(0, n - 1)].a] = 1'b1;
         run_session(1'($urandom), 1'($urandom), 1'($urandom));
         for (int i = 0; i < 256; i++) bad[i] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
